// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

    localparam int BUF_DEPTH_DEFAULT = 2;
    localparam int INSTR_BYTES       = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory, decode handshake and control signals of the fetch controller
interface fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        misalign_err;

    modport master (
        output imem_addr, instr_out, pc_out, instr_valid, misalign_err,
        input  imem_instr, instr_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_addr, instr_out, pc_out, instr_valid, misalign_err,
        output imem_instr, instr_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry shift FIFO of {pc, instr} with push/pop/flush
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fetch_entry_t entry0;
    fetch_entry_t entry1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = (count != 2'd0) ? entry0 : '0;

    // entry0 is always the head; a pop shifts entry1 forward
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= push_data;
                    else               entry1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    entry1 <= '0;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - sequential instruction fetch with redirect, halt and a 2-entry decode buffer
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic         misalign_err_q;
    logic [1:0]   count;
    logic [1:0]   count_after;
    logic         instr_valid;
    logic         push;
    logic         pop;
    logic         bad_target;
    fetch_entry_t head;

    assign bad_target  = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign instr_valid = (count != 2'd0);
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (push),
        .pop       (pop),
        .push_data ('{pc: fetch_pc, instr: bus.imem_instr}),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_next;
    end

    // redirect overrides halt; a sticky misalign keeps the fetcher parked
    always_comb begin
        state_next = state;
        if (bus.redirect)
            state_next = (bad_target || misalign_err_q) ? ST_HALTED : ST_RUN;
        else if (bus.halt || misalign_err_q)
            state_next = ST_HALTED;
        else
            state_next = (count_after == FULL_CNT) ? ST_FULL : ST_RUN;
    end

    always_comb begin
        pop  = instr_valid && bus.instr_ready && !bus.redirect;
        push = (state == ST_RUN) && !bus.redirect && ((count != FULL_CNT) || pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc       <= RESET_PC;
            misalign_err_q <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            if (bad_target) misalign_err_q <= 1'b1;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        end
    end

    assign bus.imem_addr    = fetch_pc;
    assign bus.instr_valid  = instr_valid;
    assign bus.instr_out    = head.instr;
    assign bus.pc_out       = head.pc;
    assign bus.misalign_err = misalign_err_q;

endmodule
